// File: rtl/vertex_project_pipe_pkg.sv
// rtl/vertex_project_pipe_pkg.sv - shared types and helpers for the vertex projection pipe
package vp_pkg;

    localparam int DW_DEF   = 24;
    localparam int FRAC_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } vp_state_t;

    function automatic logic signed [63:0] ident_elem(input int row, input int col, input int frac);
        return (row == col) ? (64'sd1 <<< frac) : 64'sd0;
    endfunction

    // Clamp a wide signed value into the range of a dw-bit two's complement number.
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/vertex_project_pipe_if.sv
// rtl/vertex_project_pipe_if.sv - config and primitive handshake bundle for the projection pipe
interface vertex_project_pipe_if #(
    parameter int DW    = 24,
    parameter int VERTS = 3
);
    logic                         cfg_we;
    logic [1:0]                   cfg_row;
    logic [1:0]                   cfg_col;
    logic [DW-1:0]                cfg_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [VERTS-1:0][3:0][DW-1:0] in_vtx;
    logic                         out_valid;
    logic                         out_ready;
    logic [VERTS-1:0][3:0][DW-1:0] out_vtx;
    logic                         out_sat;

    modport slave (
        input  cfg_we, cfg_row, cfg_col, cfg_data, in_valid, in_vtx, out_ready,
        output in_ready, out_valid, out_vtx, out_sat
    );

    modport master (
        output cfg_we, cfg_row, cfg_col, cfg_data, in_valid, in_vtx, out_ready,
        input  in_ready, out_valid, out_vtx, out_sat
    );
endinterface

// File: rtl/vertex_project_pipe_dot4.sv
// rtl/vertex_project_pipe_dot4.sv - combinational 4-term fixed-point dot product with clamp
module vp_dot4
    import vp_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic [3:0][DW-1:0] m_row,
    input  logic [3:0][DW-1:0] vtx,
    output logic [DW-1:0]      result,
    output logic               sat
);
    localparam int SW = 2 * DW + 2;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic signed [63:0]   wide;
    logic signed [63:0]   clamped;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            sum = sum + SW'($signed(m_row[k])) * SW'($signed(vtx[k]));
        end
        // Arithmetic shift floors toward minus infinity; no rounding is applied.
        shifted = sum >>> FRAC;
        wide    = 64'(shifted);
        clamped = sat_dw(wide, DW);
        sat     = (clamped != wide);
        result  = clamped[DW-1:0];
    end
endmodule

// File: rtl/vertex_project_pipe.sv
// rtl/vertex_project_pipe.sv - loadable 4x4 matrix transform over one primitive via a shared dot unit
module vertex_project_pipe
    import vp_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int VERTS = 3
) (
    input logic                  sysclk,
    input logic                  reset,
    vertex_project_pipe_if.slave bus
);
    localparam int VW = (VERTS > 1) ? $clog2(VERTS) : 1;

    typedef logic [3:0][3:0][DW-1:0]       mat_t;
    typedef logic [VERTS-1:0][3:0][DW-1:0] prim_t;

    vp_state_t     state_q, state_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    r_q, r_d;
    logic          sat_q, sat_d;
    mat_t          m_q, m_d, ident_m;
    prim_t         vtx_q, vtx_d, out_q, out_d;
    logic [DW-1:0] dot_res;
    logic          dot_sat;

    always_comb begin
        ident_m = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ident_m[r][c] = DW'(ident_elem(r, c, FRAC));
            end
        end
    end

    vp_dot4 #(.DW(DW), .FRAC(FRAC)) u_dot (
        .m_row  (m_q[r_q]),
        .vtx    (vtx_q[v_q]),
        .result (dot_res),
        .sat    (dot_sat)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            v_q     <= '0;
            r_q     <= '0;
            sat_q   <= 1'b0;
            m_q     <= ident_m;
            vtx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            r_q     <= r_d;
            sat_q   <= sat_d;
            m_q     <= m_d;
            vtx_q   <= vtx_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        r_d     = r_q;
        sat_d   = sat_q;
        m_d     = m_q;
        vtx_d   = vtx_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                // Matrix writes land before the accept so the new primitive sees them.
                if (bus.cfg_we) begin
                    m_d[bus.cfg_row][bus.cfg_col] = bus.cfg_data;
                end
                if (bus.in_valid) begin
                    vtx_d   = bus.in_vtx;
                    v_d     = '0;
                    r_d     = '0;
                    sat_d   = 1'b0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                out_d[v_q][r_q] = dot_res;
                sat_d           = sat_q | dot_sat;
                if (r_q == 2'd3) begin
                    r_d = '0;
                    if (v_q == VW'(VERTS - 1)) begin
                        v_d     = '0;
                        state_d = ST_HOLD;
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                end else begin
                    r_d = r_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_HOLD);
        bus.out_vtx   = out_q;
        bus.out_sat   = sat_q;
    end
endmodule

// File: tb/tb_vertex_project_pipe.sv
// tb/tb_vertex_project_pipe.sv - directed bench for vertex_project_pipe with arithmetic reference model
module tb_vertex_project_pipe;
    localparam int DW    = 24;
    localparam int FRAC  = 12;
    localparam int VERTS = 3;

    typedef logic [VERTS-1:0][3:0][DW-1:0] vec_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;

    int   mdl_m[4][4];
    vec_t exp_vtx;
    logic exp_sat;
    logic exp_valid = 1'b0;

    vertex_project_pipe_if #(.DW(DW), .VERTS(VERTS)) bus ();

    vertex_project_pipe #(.DW(DW), .FRAC(FRAC), .VERTS(VERTS)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_ident();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mdl_m[r][c] = (r == c) ? (1 << FRAC) : 0;
    endtask

    // Reference: floor((M * v) / 2^FRAC) per element, clamped to DW-bit signed range.
    task automatic model_prim(input vec_t vin);
        longint acc;
        exp_sat = 1'b0;
        for (int v = 0; v < VERTS; v++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc += longint'(mdl_m[r][k]) * longint'($signed(vin[v][k]));
                acc = acc >>> FRAC;
                if (acc > 64'sd8388607) begin
                    acc = 64'sd8388607; exp_sat = 1'b1;
                end else if (acc < -64'sd8388608) begin
                    acc = -64'sd8388608; exp_sat = 1'b1;
                end
                exp_vtx[v][r] = acc[DW-1:0];
            end
        end
    endtask

    function automatic vec_t mkv(input int x, input int y, input int z, input int w);
        vec_t t;
        for (int v = 0; v < VERTS; v++) begin
            t[v][0] = x[DW-1:0];
            t[v][1] = y[DW-1:0];
            t[v][2] = z[DW-1:0];
            t[v][3] = w[DW-1:0];
        end
        return t;
    endfunction

    always @(negedge sysclk) begin
        if (!reset && exp_valid && bus.out_valid) begin
            for (int v = 0; v < VERTS; v++)
                for (int r = 0; r < 4; r++)
                    chk($sformatf("cmp_vtx[%0d][%0d]", v, r), bus.out_vtx[v][r], exp_vtx[v][r]);
            chk("cmp_sat", bus.out_sat, exp_sat);
            chk("cmp_in_ready_hold", bus.in_ready, 1'b0);
        end
    end

    task automatic chk_reset_state(input string nm);
        chk({nm, "_in_ready"}, bus.in_ready, 1'b1);
        chk({nm, "_out_valid"}, bus.out_valid, 1'b0);
        chk({nm, "_out_sat"}, bus.out_sat, 1'b0);
        for (int v = 0; v < VERTS; v++)
            for (int r = 0; r < 4; r++)
                chk($sformatf("%s_vtx[%0d][%0d]", nm, v, r), bus.out_vtx[v][r], '0);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        exp_valid = 1'b0;
        model_ident();
        #1;
        chk_reset_state("reset");
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    task automatic cfg_wr(input int r, input int c, input int d, input bit lands);
        @(negedge sysclk);
        bus.cfg_we   = 1'b1;
        bus.cfg_row  = r[1:0];
        bus.cfg_col  = c[1:0];
        bus.cfg_data = d[DW-1:0];
        @(posedge sysclk);
        #1 bus.cfg_we = 1'b0;
        if (lands) mdl_m[r][c] = d;
    endtask

    task automatic accept(input vec_t vin, input bit wr, input int r, input int c, input int d);
        @(negedge sysclk);
        if (wr) begin
            mdl_m[r][c]  = d;
            bus.cfg_we   = 1'b1;
            bus.cfg_row  = r[1:0];
            bus.cfg_col  = c[1:0];
            bus.cfg_data = d[DW-1:0];
        end
        model_prim(vin);
        bus.in_vtx   = vin;
        bus.in_valid = 1'b1;
        chk("accept_in_ready", bus.in_ready, 1'b1);
        @(posedge sysclk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        acc_cyc      = cyc;
        exp_valid    = 1'b1;
        chk("calc_in_ready", bus.in_ready, 1'b0);
        chk("calc_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 40 && !bus.out_valid; i++) begin
            @(posedge sysclk);
            #1;
        end
        chk("hold_reached", bus.out_valid, 1'b1);
        chk("hold_latency", 64'(cyc - acc_cyc), 64'd12);
    endtask

    task automatic release_out(input int hold);
        vec_t snap;
        snap = bus.out_vtx;
        for (int i = 0; i < hold; i++) begin
            @(negedge sysclk);
            chk("hold_stable", bus.out_vtx == snap, 1'b1);
            chk("hold_valid", bus.out_valid, 1'b1);
        end
        @(negedge sysclk);
        bus.out_ready = 1'b1;
        @(posedge sysclk);
        #1;
        bus.out_ready = 1'b0;
        exp_valid = 1'b0;
        chk("release_out_valid", bus.out_valid, 1'b0);
        chk("release_in_ready", bus.in_ready, 1'b1);
        chk("release_vtx_kept", bus.out_vtx == snap, 1'b1);
    endtask

    task automatic lit(input string nm, input int v, input int r, input int val);
        logic [DW-1:0] e;
        e = val[DW-1:0];
        chk({nm, "_dut"}, bus.out_vtx[v][r], e);
        chk({nm, "_model"}, exp_vtx[v][r], e);
    endtask

    initial begin
        vec_t t;
        bus.cfg_we = 1'b0; bus.cfg_row = '0; bus.cfg_col = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_vtx = '0; bus.out_ready = 1'b0;
        model_ident();
        repeat (2) @(posedge sysclk);
        #1 chk_reset_state("por");
        @(negedge sysclk);
        reset = 1'b0;

        // Identity pass-through
        accept(mkv(4096, 8192, -4096, 4096), 1'b0, 0, 0, 0);
        wait_hold();
        lit("ident_x", 0, 0, 4096);
        lit("ident_y", 1, 1, 8192);
        lit("ident_z", 2, 2, -4096);
        lit("ident_w", 2, 3, 4096);
        chk("ident_sat", bus.out_sat, 1'b0);
        release_out(0);

        // Loaded matrix
        do_reset();
        cfg_wr(0, 0, 8192, 1'b1);
        cfg_wr(2, 3, 4096, 1'b1);
        cfg_wr(3, 2, -4096, 1'b1);
        cfg_wr(3, 3, 0, 1'b1);
        accept(mkv(4096, 4096, 4096, 4096), 1'b0, 0, 0, 0);
        wait_hold();
        lit("mat_x", 1, 0, 8192);
        lit("mat_y", 1, 1, 4096);
        lit("mat_z", 1, 2, 8192);
        lit("mat_w", 1, 3, -4096);
        release_out(2);

        // Saturation, then an exact max value that does not saturate
        do_reset();
        cfg_wr(0, 0, 'h7FFFFF, 1'b1);
        accept(mkv('h7FFFFF, 0, 0, 0), 1'b0, 0, 0, 0);
        wait_hold();
        lit("sat_x", 0, 0, 8388607);
        chk("sat_flag", bus.out_sat, 1'b1);
        release_out(1);
        accept(mkv(4096, 0, 0, 0), 1'b0, 0, 0, 0);
        wait_hold();
        lit("nosat_x", 2, 0, 8388607);
        chk("nosat_flag", bus.out_sat, 1'b0);
        release_out(0);

        // Floor on negative
        do_reset();
        cfg_wr(0, 0, 2048, 1'b1);
        accept(mkv(-1, 0, 0, 0), 1'b0, 0, 0, 0);
        wait_hold();
        lit("floor_x", 0, 0, -1);
        release_out(0);

        // Matrix write during CALC is dropped; same write in IDLE lands
        do_reset();
        t = mkv(100, 4096, -300, 4096);
        t[1][1] = 24'd2048;
        accept(t, 1'b0, 0, 0, 0);
        cfg_wr(1, 1, 8192, 1'b0);
        wait_hold();
        lit("busywr_y0", 0, 1, 4096);
        lit("busywr_y1", 1, 1, 2048);
        release_out(0);
        accept(t, 1'b0, 0, 0, 0);
        wait_hold();
        lit("busywr_next_y", 0, 1, 4096);
        release_out(0);
        cfg_wr(1, 1, 8192, 1'b1);
        accept(t, 1'b0, 0, 0, 0);
        wait_hold();
        lit("idlewr_y0", 0, 1, 8192);
        lit("idlewr_y1", 1, 1, 4096);
        release_out(0);

        // Write and accept in the same cycle
        accept(mkv(4096, 4096, 0, 0), 1'b1, 0, 0, 12288);
        wait_hold();
        lit("samecyc_x", 0, 0, 12288);
        release_out(0);

        // Long hold, then reset mid-CALC
        t = mkv(-8192, 300, 4096, -4096);
        t[2][0] = 24'h000123;
        accept(t, 1'b0, 0, 0, 0);
        wait_hold();
        release_out(20);
        accept(mkv(4096, 4096, 4096, 4096), 1'b0, 0, 0, 0);
        repeat (5) @(posedge sysclk);
        #2;
        reset = 1'b1;
        exp_valid = 1'b0;
        model_ident();
        #1;
        chk("midcalc_out_valid", bus.out_valid, 1'b0);
        chk("midcalc_in_ready", bus.in_ready, 1'b1);
        chk("midcalc_out_sat", bus.out_sat, 1'b0);
        @(negedge sysclk);
        reset = 1'b0;

        // out_ready while nothing is held is ignored
        bus.out_ready = 1'b1;
        repeat (2) @(negedge sysclk);
        chk("idle_ready_out_valid", bus.out_valid, 1'b0);
        chk("idle_ready_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;

        accept(mkv(4096, 8192, -4096, 4096), 1'b0, 0, 0, 0);
        wait_hold();
        lit("postrst_x", 0, 0, 4096);
        lit("postrst_y", 1, 1, 8192);
        lit("postrst_z", 2, 2, -4096);
        release_out(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
